op_lastn: RTL and testbench

Streaming window arithmetic unit that keeps the last N accepted input samples and produces either their product or their sum. Samples equal to a programmable "ignore" value are dropped. The combination is computed iteratively, one operation per cycle, and the result is flagged with a one-cycle valid pulse. It is the generalised successor of the two-value multiplier: depth N is configurable, there is a sum mode, and there is a busy/valid handshake.

---
 rtl/op_lastn.sv | 115 +++++++++++
 tb/tb_op_lastn.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/op_lastn.sv
// op_lastn: keeps the last N accepted samples and combines them.
// When a new sample fills or refreshes the window, the unit multiplies
// the window contents (mode=0) or adds them (mode=1). It does one
// operation per cycle. Samples equal to the programmable ignore value
// are dropped.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in        sample input; also the new ignore value when ld=1
//   in_valid  sample strobe
//   ld        load ignore value from in (has priority over in_valid)
//   mode      0 = product, 1 = sum; latched when a computation starts
//   busy      computation in progress; samples are refused
//   out       last result, zero-extended to N*W bits
//   out_valid one-cycle pulse when out is updated
//   cnt       samples held in the window, saturating at N
module op_lastn #(
    parameter int          W   = 4,
    parameter int          N   = 2,
    parameter logic [W-1:0] IGN = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             in,
    input  logic                     in_valid,
    input  logic                     ld,
    input  logic                     mode,
    output logic                     busy,
    output logic [N*W-1:0]           out,
    output logic                     out_valid,
    output logic [$clog2(N+1)-1:0]   cnt
);

    localparam int AW = N * W;
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t         state;
    logic [W-1:0]   win [N];
    logic [W-1:0]   ign;
    logic [AW-1:0]  acc;
    logic [IW-1:0]  idx;
    logic           op;

    logic           accept;
    logic [CW-1:0]  cnt_next;
    logic [AW-1:0]  operand;
    logic [AW-1:0]  step;

    always_comb begin
        accept   = in_valid & ~ld & ~busy & (in != ign);
        cnt_next = cnt;
        if (accept && cnt != CW'(N))
            cnt_next = cnt + CW'(1);
        operand = AW'(win[idx]);
        // The product of N W-bit values fits in AW bits, so truncation is exact.
        step = op ? (acc + operand) : (acc * operand);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            for (int unsigned i = 0; i < N; i++)
                win[i] <= '0;
            ign       <= IGN;
            acc       <= '0;
            idx       <= '0;
            op        <= 1'b0;
            busy      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (ld)
                ign <= in;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int unsigned i = N - 1; i > 0; i--)
                            win[i] <= win[i-1];
                        win[0] <= in;
                        cnt    <= cnt_next;
                        // The incoming sample is buf[0], so it seeds the accumulator.
                        if (cnt_next == CW'(N)) begin
                            acc   <= AW'(in);
                            idx   <= IW'(1);
                            op    <= mode;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= step;
                    idx <= idx + IW'(1);
                    if (idx == IW'(N - 1)) begin
                        out       <= step;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_lastn.sv
// Testbench for op_lastn (W=4, N=3, IGN=0). It first runs a directed
// vector table with a reset-during-computation sequence. Then it drives
// random traffic and compares the outputs to a queue-based reference model.
module tb_op_lastn;

    localparam int          W   = 4;
    localparam int          N   = 3;
    localparam logic [W-1:0] IGN = 4'd0;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     din;
    logic             in_valid;
    logic             ld;
    logic             mode;
    logic             busy;
    logic [N*W-1:0]   out;
    logic             out_valid;
    logic [1:0]       cnt;

    always #5 clk = ~clk;

    op_lastn #(.W(W), .N(N), .IGN(IGN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_valid  (in_valid),
        .ld        (ld),
        .mode      (mode),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid),
        .cnt       (cnt)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: window as a queue (newest first), plus a countdown
    // of remaining busy cycles and the precomputed pending result.
    int q[$];
    int m_ign, m_left, m_pend, m_out, m_valid;

    task automatic model_reset();
        q.delete();
        m_ign = int'(IGN); m_left = 0; m_pend = 0; m_out = 0; m_valid = 0;
    endtask

    task automatic model_step(input int l, input int v, input int m, input int d);
        int r;
        m_valid = 0;
        if (l != 0) m_ign = d;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_out = m_pend;
                m_valid = 1;
            end
        end else if (v != 0 && l == 0 && d != m_ign) begin
            q.push_front(d);
            if (q.size() > N) void'(q.pop_back());
            if (q.size() == N) begin
                r = (m != 0) ? 0 : 1;
                foreach (q[i]) r = (m != 0) ? r + q[i] : r * q[i];
                m_pend = r;
                m_left = N - 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out"},       int'(out),       m_out);
        chk({tag, ".out_valid"}, int'(out_valid), m_valid);
        chk({tag, ".busy"},      int'(busy),      (m_left > 0) ? 1 : 0);
        chk({tag, ".cnt"},       int'(cnt),       q.size());
    endtask

    task automatic drive(input logic l, input logic v, input logic m, input logic [W-1:0] d);
        @(negedge clk);
        ld = l; in_valid = v; mode = m; din = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       ld;
        logic       iv;
        logic       mode;
        logic [3:0] din;
        int         eo;
        int         ev;
        int         eb;
        int         ec;
    } vec_t;

    function automatic vec_t mk(input logic l, input logic v, input logic m, input logic [3:0] d,
                                input int eo, input int ev, input int eb, input int ec);
        vec_t t;
        t.ld = l; t.iv = v; t.mode = m; t.din = d;
        t.eo = eo; t.ev = ev; t.eb = eb; t.ec = ec;
        return t;
    endfunction

    vec_t tbl[24];

    initial begin
        tbl[0]  = mk(0, 1, 0, 4'd2,    0, 0, 0, 1);
        tbl[1]  = mk(0, 1, 0, 4'd3,    0, 0, 0, 2);
        tbl[2]  = mk(0, 1, 0, 4'd4,    0, 0, 1, 3);
        tbl[3]  = mk(0, 0, 0, 4'd0,    0, 0, 1, 3);
        tbl[4]  = mk(0, 0, 0, 4'd0,   24, 1, 0, 3);
        tbl[5]  = mk(0, 0, 0, 4'd0,   24, 0, 0, 3);
        tbl[6]  = mk(0, 1, 0, 4'd0,   24, 0, 0, 3);  // equals ignore value
        tbl[7]  = mk(0, 1, 0, 4'd5,   24, 0, 1, 3);
        tbl[8]  = mk(0, 0, 0, 4'd0,   24, 0, 1, 3);
        tbl[9]  = mk(0, 0, 0, 4'd0,   60, 1, 0, 3);
        tbl[10] = mk(1, 1, 0, 4'd5,   60, 0, 0, 3);  // ld wins over in_valid
        tbl[11] = mk(0, 1, 0, 4'd5,   60, 0, 0, 3);
        tbl[12] = mk(0, 1, 0, 4'd15,  60, 0, 1, 3);
        tbl[13] = mk(0, 0, 0, 4'd0,   60, 0, 1, 3);
        tbl[14] = mk(0, 0, 0, 4'd0,  300, 1, 0, 3);
        tbl[15] = mk(0, 1, 1, 4'd15, 300, 0, 1, 3);
        tbl[16] = mk(0, 0, 0, 4'd0,  300, 0, 1, 3);  // mode flips mid-computation
        tbl[17] = mk(0, 0, 0, 4'd0,   35, 1, 0, 3);
        tbl[18] = mk(0, 1, 0, 4'd1,   35, 0, 1, 3);
        tbl[19] = mk(0, 1, 0, 4'd2,   35, 0, 1, 3);  // refused while busy
        tbl[20] = mk(0, 0, 0, 4'd0,  225, 1, 0, 3);
        tbl[21] = mk(0, 1, 0, 4'd2,  225, 0, 1, 3);
        tbl[22] = mk(0, 0, 0, 4'd0,  225, 0, 1, 3);
        tbl[23] = mk(0, 0, 0, 4'd0,   30, 1, 0, 3);

        rst = 1'b1; ld = 1'b0; in_valid = 1'b0; mode = 1'b0; din = '0;
        model_reset();
        #12;
        chk("rst.out",       int'(out),       0);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.busy",      int'(busy),      0);
        chk("rst.cnt",       int'(cnt),       0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].ld, tbl[i].iv, tbl[i].mode, tbl[i].din);
            model_step(int'(tbl[i].ld), int'(tbl[i].iv), int'(tbl[i].mode), int'(tbl[i].din));
            chk($sformatf("vec%0d.out", i),       int'(out),       tbl[i].eo);
            chk($sformatf("vec%0d.out_valid", i), int'(out_valid), tbl[i].ev);
            chk($sformatf("vec%0d.busy", i),      int'(busy),      tbl[i].eb);
            chk($sformatf("vec%0d.cnt", i),       int'(cnt),       tbl[i].ec);
        end

        // Reset in the middle of a computation.
        drive(1'b0, 1'b1, 1'b0, 4'd3);
        model_step(0, 1, 0, 3);
        chk("abort.busy_before", int'(busy), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort.out",       int'(out),       0);
        chk("abort.out_valid", int'(out_valid), 0);
        chk("abort.busy",      int'(busy),      0);
        chk("abort.cnt",       int'(cnt),       0);
        model_reset();
        @(posedge clk);
        #1;
        chk("abort.no_pulse", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 4'd5);
        model_step(0, 1, 0, 5);
        chk("post_rst.cnt",  int'(cnt),  1);
        chk("post_rst.busy", int'(busy), 0);
        chk("post_rst.out",  int'(out),  0);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic l, v, m;
            logic [W-1:0] d;
            l = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 9) < 7);
            m = 1'($urandom_range(0, 1));
            d = W'($urandom_range(0, 15));
            drive(l, v, m, d);
            model_step(int'(l), int'(v), int'(m), int'(d));
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
